decode_exec_unit: RTL and testbench

DECODE_EXEC_UNIT -- requirements
Module: decode_exec_unit

---
 rtl/decode_exec_unit_pkg.sv | 59 +++++
 rtl/decode_exec_unit_imm_gen.sv | 41 ++++
 rtl/decode_exec_unit.sv | 151 +++++++++++++++
 tb/tb_decode_exec_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_exec_unit_pkg.sv
// -----------------------------------------------------------------------------
// decode_exec_unit_pkg
// Shared constants for the RV32 decode/execute slice:
//   - 7-bit opcode values for each supported instruction class
//   - ALU operation encoding (alu_op_t)
//   - func3 values used by the decoder
//   - helper that maps an ALU-class func3 onto an ALU operation
// -----------------------------------------------------------------------------
package decode_exec_unit_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // ALU-class func3 -> operation. SLTU is executed as signed SLT and
    // SRA as logical SRL; this core has no unsigned-compare or arithmetic shift.
    function automatic alu_op_t func3_to_alu_op(input logic [2:0] func3,
                                                input logic       sub);
        alu_op_t op;
        case (func3)
            F3_ADD:  op = sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_exec_unit_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Extracts and sign-extends the immediate field of an RV32 instruction.
// Branch and jump immediates are half-offsets (bit 0 is not appended).
// Ports:
//   instruction : input,  32   instruction word
//   imm         : output, XLEN sign-extended immediate (0 for formats without one)
// -----------------------------------------------------------------------------
module imm_gen
    import decode_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    assign opcode = instruction[6:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        imm = '0;
        case (opcode)
            OP_I_ALU, OP_LOAD, OP_JALR:
                imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                       instruction[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-12){instruction[31]}}, instruction[31],
                       instruction[7], instruction[30:25], instruction[11:8]};
            OP_JAL:
                imm = {{(XLEN-20){instruction[31]}}, instruction[31],
                       instruction[19:12], instruction[20], instruction[30:21]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_exec_unit.sv
// -----------------------------------------------------------------------------
// decode_exec_unit
// Single-cycle RV32 decode + ALU slice. Everything except `halted` is a pure
// combinational function of instruction/rs1Data/rs2Data.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (halted only)
//   instruction         : 32-bit instruction word
//   rs1Data, rs2Data    : register read data (rs1 is ALU operand A)
//   imm                 : sign-extended immediate
//   aluResult, zero     : ALU result and its zero flag
//   BR, memToReg, memWrite, ALUSrc, regWrite, PCToReg, aluToPC : controls
//   ALUOp               : selected ALU operation
//   brTaken             : branch/jump taken
//   halt                : current instruction is SYSTEM
//   halted              : sticky halt flag, cleared only by reset
// -----------------------------------------------------------------------------
module decode_exec_unit
    import decode_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] aluResult,
    output logic            zero,
    output logic            BR,
    output logic            memToReg,
    output logic            memWrite,
    output logic            ALUSrc,
    output logic            regWrite,
    output logic            PCToReg,
    output logic            aluToPC,
    output logic [2:0]      ALUOp,
    output logic            brTaken,
    output logic            halt,
    output logic            halted
);

    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7_b5;
    alu_op_t         alu_op;
    logic [XLEN-1:0] operand_b;

    assign opcode   = instruction[6:0];
    assign func3    = instruction[14:12];
    assign func7_b5 = instruction[30];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (instruction),
        .imm         (imm)
    );

    // Main decoder.
    always_comb begin
        BR       = 1'b0;
        memToReg = 1'b0;
        memWrite = 1'b0;
        ALUSrc   = 1'b0;
        regWrite = 1'b0;
        PCToReg  = 1'b0;
        aluToPC  = 1'b0;
        halt     = 1'b0;
        alu_op   = ALU_ADD;
        case (opcode)
            OP_R_TYPE: begin
                regWrite = 1'b1;
                alu_op   = func3_to_alu_op(func3, func7_b5);
            end
            OP_I_ALU: begin
                // func7 is ignored: there is no SUBI.
                regWrite = 1'b1;
                ALUSrc   = 1'b1;
                alu_op   = func3_to_alu_op(func3, 1'b0);
            end
            OP_LOAD: begin
                regWrite = 1'b1;
                ALUSrc   = 1'b1;
                memToReg = 1'b1;
            end
            OP_STORE: begin
                memWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_BRANCH: begin
                BR     = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_JAL: begin
                BR       = 1'b1;
                PCToReg  = 1'b1;
                regWrite = 1'b1;
            end
            OP_JALR: begin
                BR       = 1'b1;
                PCToReg  = 1'b1;
                regWrite = 1'b1;
                aluToPC  = 1'b1;
                ALUSrc   = 1'b1;
            end
            OP_SYSTEM: halt = 1'b1;
            default: ;
        endcase
    end

    assign ALUOp     = alu_op;
    assign operand_b = ALUSrc ? imm : rs2Data;

    always_comb begin
        aluResult = '0;
        case (alu_op)
            ALU_ADD: aluResult = rs1Data + operand_b;
            ALU_SUB: aluResult = rs1Data - operand_b;
            ALU_AND: aluResult = rs1Data & operand_b;
            ALU_OR:  aluResult = rs1Data | operand_b;
            ALU_XOR: aluResult = rs1Data ^ operand_b;
            ALU_SLL: aluResult = rs1Data << operand_b[4:0];
            ALU_SRL: aluResult = rs1Data >> operand_b[4:0];
            ALU_SLT: aluResult = {{(XLEN-1){1'b0}},
                                  ($signed(rs1Data) < $signed(operand_b))};
            default: aluResult = '0;
        endcase
    end

    assign zero = (aluResult == '0);

    // Jumps are unconditional; conditional branches use the SUB zero flag,
    // inverted for BNE.
    always_comb begin
        if (opcode == OP_JAL || opcode == OP_JALR) begin
            brTaken = 1'b1;
        end else begin
            brTaken = BR && ((func3 == F3_BNE) ? ~zero : zero);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // sequential element samples pre-edge values.
        if (reset) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_decode_exec_unit
// Self-checking bench for decode_exec_unit: directed cases followed by random
// instructions, compared against a behavioural instruction-level model.
// -----------------------------------------------------------------------------
module tb_decode_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [31:0] aluResult;
    logic        zero, BR, memToReg, memWrite, ALUSrc, regWrite, PCToReg, aluToPC;
    logic [2:0]  ALUOp;
    logic        brTaken, halt, halted;

    int total = 0;
    int bad   = 0;
    logic model_halted = 1'b0;

    decode_exec_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .rs1Data     (rs1Data),
        .rs2Data     (rs2Data),
        .imm         (imm),
        .aluResult   (aluResult),
        .zero        (zero),
        .BR          (BR),
        .memToReg    (memToReg),
        .memWrite    (memWrite),
        .ALUSrc      (ALUSrc),
        .regWrite    (regWrite),
        .PCToReg     (PCToReg),
        .aluToPC     (aluToPC),
        .ALUOp       (ALUOp),
        .brTaken     (brTaken),
        .halt        (halt),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] alu;
        logic        zero;
        logic        br;
        logic        m2r;
        logic        mw;
        logic        asrc;
        logic        rw;
        logic        pc2r;
        logic        a2pc;
        logic [2:0]  op;
        logic        taken;
        logic        halt;
    } exp_t;

    string alu_names [8] = '{"ADD", "SLL", "SLT", "SLT", "XOR", "SRL", "OR", "AND"};
    logic [6:0] opcodes [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011,
                                7'b0001111};

    function automatic logic [2:0] op_code_of(input string name);
        case (name)
            "SUB":   return 3'd1;
            "AND":   return 3'd2;
            "OR":    return 3'd3;
            "XOR":   return 3'd4;
            "SLL":   return 3'd5;
            "SRL":   return 3'd6;
            "SLT":   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Instruction-level reference: what the instruction means, not how it is decoded.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t               e;
        string              name;
        logic [31:0]        opb;
        logic signed [11:0] i12;
        logic signed [19:0] i20;
        logic [2:0]         f3;
        e    = '0;
        name = "ADD";
        f3   = ins[14:12];
        case (ins[6:0])
            7'b0110011: begin
                e.rw = 1;
                name = alu_names[f3];
                if (f3 == 3'd0 && ins[30]) name = "SUB";
            end
            7'b0010011: begin
                e.rw = 1; e.asrc = 1;
                name = alu_names[f3];
                i12 = ins[31:20]; e.imm = i12;
            end
            7'b0000011: begin
                e.rw = 1; e.asrc = 1; e.m2r = 1;
                i12 = ins[31:20]; e.imm = i12;
            end
            7'b0100011: begin
                e.mw = 1; e.asrc = 1;
                i12 = {ins[31:25], ins[11:7]}; e.imm = i12;
            end
            7'b1100011: begin
                e.br = 1; name = "SUB";
                i12 = {ins[31], ins[7], ins[30:25], ins[11:8]}; e.imm = i12;
            end
            7'b1101111: begin
                e.br = 1; e.pc2r = 1; e.rw = 1;
                i20 = {ins[31], ins[19:12], ins[20], ins[30:21]}; e.imm = i20;
            end
            7'b1100111: begin
                e.br = 1; e.pc2r = 1; e.rw = 1; e.a2pc = 1; e.asrc = 1;
                i12 = ins[31:20]; e.imm = i12;
            end
            7'b1110011: e.halt = 1;
            default: ;
        endcase
        opb = e.asrc ? e.imm : b;
        case (name)
            "SUB":   e.alu = a - opb;
            "AND":   e.alu = a & opb;
            "OR":    e.alu = a | opb;
            "XOR":   e.alu = a ^ opb;
            "SLL":   e.alu = a << opb[4:0];
            "SRL":   e.alu = a >> opb[4:0];
            "SLT":   e.alu = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            default: e.alu = a + opb;
        endcase
        e.op   = op_code_of(name);
        e.zero = (e.alu == 32'd0);
        if (ins[6:0] == 7'b1101111 || ins[6:0] == 7'b1100111) e.taken = 1;
        else if (ins[6:0] == 7'b1100011) e.taken = (f3 == 3'b001) ? !e.zero : e.zero;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge and check every combinational output.
    task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        exp_t e;
        @(negedge clk);
        instruction = ins;
        rs1Data     = a;
        rs2Data     = b;
        reset       = rst;
        #1;
        e = model(ins, a, b);
        check("imm",       imm,              e.imm);
        check("aluResult", aluResult,        e.alu);
        check("zero",      32'(zero),        32'(e.zero));
        check("BR",        32'(BR),          32'(e.br));
        check("memToReg",  32'(memToReg),    32'(e.m2r));
        check("memWrite",  32'(memWrite),    32'(e.mw));
        check("ALUSrc",    32'(ALUSrc),      32'(e.asrc));
        check("regWrite",  32'(regWrite),    32'(e.rw));
        check("PCToReg",   32'(PCToReg),     32'(e.pc2r));
        check("aluToPC",   32'(aluToPC),     32'(e.a2pc));
        check("ALUOp",     32'(ALUOp),       32'(e.op));
        check("brTaken",   32'(brTaken),     32'(e.taken));
        check("halt",      32'(halt),        32'(e.halt));
    endtask

    // Clock the currently driven inputs and check the sticky flag.
    task automatic tick();
        exp_t e;
        e = model(instruction, rs1Data, rs2Data);
        @(posedge clk);
        if (reset) model_halted = 1'b0;
        else if (e.halt) model_halted = 1'b1;
        #1;
        check("halted", 32'(halted), 32'(model_halted));
    endtask

    initial begin
        logic [31:0] ins, a, b;
        int          k;

        // Reset with a NOP on the bus.
        drive(32'h0000_0000, 32'd0, 32'd0, 1'b1);
        tick();
        check("reset_halted", 32'(halted), 32'd0);

        // ADD x3,x1,x2
        drive(32'h0020_81B3, 32'd5, 32'd7, 1'b0);
        check("add_result", aluResult, 32'd12);
        check("add_rw", 32'(regWrite), 32'd1);
        check("add_op", 32'(ALUOp), 32'd0);
        tick();

        // SUB equal operands, then BNE / BEQ on the same operands.
        drive(32'h4020_81B3, 32'd9, 32'd9, 1'b0);
        check("sub_result", aluResult, 32'd0);
        check("sub_zero", 32'(zero), 32'd1);
        tick();
        drive(32'h0020_9063, 32'd9, 32'd9, 1'b0);
        check("bne_taken", 32'(brTaken), 32'd0);
        tick();
        drive(32'h0020_8063, 32'd9, 32'd9, 1'b0);
        check("beq_taken", 32'(brTaken), 32'd1);
        tick();

        // ADDI x1,x0,-1
        drive(32'hFFF0_0093, 32'd0, 32'd123, 1'b0);
        check("addi_imm", imm, 32'hFFFF_FFFF);
        check("addi_result", aluResult, 32'hFFFF_FFFF);
        tick();

        // SW x2,-4(x1)
        drive(32'hFE20_AE23, 32'd100, 32'd55, 1'b0);
        check("sw_mw", 32'(memWrite), 32'd1);
        check("sw_imm", imm, 32'hFFFF_FFFC);
        check("sw_result", aluResult, 32'd96);
        tick();

        // JAL x1,+8
        drive(32'h0080_00EF, 32'd3, 32'd4, 1'b0);
        check("jal_imm", imm, 32'd4);
        check("jal_br", 32'(BR), 32'd1);
        check("jal_pc2r", 32'(PCToReg), 32'd1);
        check("jal_taken", 32'(brTaken), 32'd1);
        tick();

        // ECALL sets halted; reset clears it, and wins over a simultaneous halt.
        drive(32'h0000_0073, 32'd0, 32'd0, 1'b0);
        check("ecall_halt", 32'(halt), 32'd1);
        tick();
        check("ecall_halted", 32'(halted), 32'd1);
        drive(32'h0000_0013, 32'd0, 32'd0, 1'b0);
        tick();
        check("halted_sticky", 32'(halted), 32'd1);
        drive(32'h0000_0073, 32'd0, 32'd0, 1'b1);
        tick();
        check("reset_over_halt", 32'(halted), 32'd0);

        // Random instructions against the model.
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            k   = $urandom_range(0, 9);
            if (k < 9) ins[6:0] = opcodes[k];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(ins, a, b, ($urandom_range(0, 15) == 0));
            tick();
        end

        drive(32'h0000_0013, 32'd0, 32'd0, 1'b1);
        tick();
        check("final_reset", 32'(halted), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
